alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Stage directly downstream of the 16-bit combinational ALU.
- Captures RESULT and the four flags at instruction accept.
- Holds the result in a one-entry buffer until the register-file write port grants it (WR_REQ/WR_ACK). Loads and the ALU share that port.
- Owns the architectural flags register, evaluates branch conditions from it, and forwards the pending result to operand fetch to avoid RAW stalls.

Parameters:
- DATA_W, 16, result/data width
- REG_AW, 4, register address width (16 registers)

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESET_N  in  1  synchronous, active-low reset
- IN_VALID  in  1  ALU output valid this cycle
- IN_READY  out  1  stage can accept
- RESULT  in  DATA_W  ALU result
- SIGN, CARRY, ZERO, PARITY  in  1 each  ALU flags
- DEST  in  REG_AW  destination register
- WB_EN  in  1  write result back (0 for CMP, BIT tests)
- FLAGS_EN  in  1  update flags register from ALU flags
- WR_REQ  out  1  write request to register file
- WR_ACK  in  1  write accepted this cycle
- WR_ADDR  out  REG_AW  write address
- WR_DATA  out  DATA_W  write data
- FLAGS_LD  in  1  load flags from FLAGS_DIN (POPF/restore)
- FLAGS_DIN  in  4  {S,C,Z,P}
- FLAGS_Q  out  4  registered flags {S,C,Z,P}: [3]=S, [2]=C, [1]=Z, [0]=P
- COND  in  4  condition code select
- COND_TRUE  out  1  condition result
- RA_ADDR, RB_ADDR  in  REG_AW  operand-fetch read addresses
- BYP_A_HIT, BYP_B_HIT  out  1 each  pending write matches the read address
- BYP_DATA  out  DATA_W  pending write data

Behaviour:
- Reset (RESET_N=0 at an edge):
  - state=EMPTY; WR_REQ=0; WR_ADDR=0; WR_DATA=0; FLAGS_Q=4'b0000.
  - Any pending write is discarded.
  - Reset dominates every other input.
- States:
  - EMPTY: nothing pending.
  - FULL: write pending.
  - WR_REQ = (state==FULL).
- IN_READY = EMPTY | (FULL & WR_ACK). Combinational; single-cycle pass-through.
- Accept = IN_VALID & IN_READY.
  - Accept with WB_EN=1: WR_ADDR<=DEST, WR_DATA<=RESULT, next state FULL.
  - Accept with WB_EN=0: no buffer entry. Next state EMPTY if the current write is acked or none is pending, else FULL.
- Write completes on WR_REQ & WR_ACK.
  - Completion with no new WB_EN accept: EMPTY next cycle.
  - Simultaneous completion + accept(WB_EN): buffer replaced, stays FULL, no bubble.
- WR_ACK while EMPTY: ignored.
- WR_ADDR/WR_DATA hold stable while WR_REQ=1 and WR_ACK=0.
- Flags register:
  - On accept with FLAGS_EN=1: FLAGS_Q <= {SIGN,CARRY,ZERO,PARITY}, independent of WB_EN and of writeback stalls.
  - On FLAGS_LD=1: FLAGS_Q <= FLAGS_DIN.
  - If FLAGS_LD and a FLAGS_EN accept occur in the same cycle, FLAGS_LD wins.
- Condition evaluation, combinational from FLAGS_Q (visible the cycle after the flag update):
  - 0 always
  - 1 Z, 2 !Z
  - 3 C, 4 !C
  - 5 S, 6 !S
  - 7 P, 8 !P
  - 9 C|Z, 10 !(C|Z)
  - 11–15 false
- Bypass:
  - BYP_A_HIT = FULL & (RA_ADDR==WR_ADDR); same rule for B with RB_ADDR.
  - BYP_DATA = WR_DATA.
  - Hits stay asserted in the ack cycle; the register file write lands at that same edge.
- No arithmetic performed; widths pass through unchanged.

Optional Feature:
- Macro: ALU_WB_FLAG_SHADOW_EN.
- When defined:
  - Adds inputs INT_ENTER and INT_RETURN and a 4-bit shadow register (reset 0).
  - INT_ENTER: shadow <= FLAGS_Q. If a FLAGS_EN accept happens in the same cycle, the shadow captures the new ALU flags.
  - INT_RETURN: FLAGS_Q <= shadow. Priority: INT_RETURN > FLAGS_LD > accept.
- When undefined: no extra ports or register; behaviour exactly as above.

Decomposition:
- Shared constants include (alongside the ALU opcode constants):
  - COND_* codes 0–10
  - FLAG_S/C/Z/P bit indices
  - ALU_WB state encodings
- One natural sub-module, cond_eval: purely combinational, FLAGS_Q + COND -> COND_TRUE. Reused by the branch unit.

Test Plan:
- Reset mid-write: FULL with WR_ACK=0, pull RESET_N low for 1 cycle -> WR_REQ=0, FLAGS_Q=0, IN_READY=1 the next cycle.
- ADD accept: RESULT=16'h1234, DEST=3, WB_EN=1, FLAGS_EN=1, WR_ACK held 0 for 3 cycles -> WR_REQ=1 with ADDR 3 / DATA 1234 stable; IN_READY=0; released on the ack.
- Back-to-back: accept R5<=0x00FF, ack the same cycle a second accept R6<=0xFF00 -> two consecutive WR_REQ cycles, no bubble, data order preserved.
- CMP (WB_EN=0, FLAGS_EN=1, ZERO=1) -> no WR_REQ; next cycle FLAGS_Q[1]=1; COND=1 gives COND_TRUE=1, COND=2 gives 0.
- Bypass: FULL with WR_ADDR=7 and data 0xBEEF, RA_ADDR=7, RB_ADDR=2 -> BYP_A_HIT=1, BYP_B_HIT=0, BYP_DATA=0xBEEF.
- Same-cycle FLAGS_LD=1 (DIN=4'b1010) and FLAGS_EN accept (flags 0101) -> FLAGS_Q=1010; with the macro defined, INT_ENTER then INT_RETURN restores the saved value.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg: shared condition codes, flag bit indices and writeback buffer states.
package alu_writeback_pkg;
  localparam int FLAG_S = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_P = 0;
  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_Z      = 4'd1;
  localparam logic [3:0] COND_NZ     = 4'd2;
  localparam logic [3:0] COND_C      = 4'd3;
  localparam logic [3:0] COND_NC     = 4'd4;
  localparam logic [3:0] COND_S      = 4'd5;
  localparam logic [3:0] COND_NS     = 4'd6;
  localparam logic [3:0] COND_P      = 4'd7;
  localparam logic [3:0] COND_NP     = 4'd8;
  localparam logic [3:0] COND_CZ     = 4'd9;
  localparam logic [3:0] COND_NCZ    = 4'd10;
  typedef enum logic {WB_EMPTY = 1'b0, WB_FULL = 1'b1} wb_state_t;
endpackage

// File: rtl/alu_writeback_cond_eval.sv
// alu_writeback_cond_eval: combinational branch condition from the {S,C,Z,P} flags register.
module alu_writeback_cond_eval
  import alu_writeback_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [3:0] i_cond,
  output logic       o_true
);
  logic w_s, w_c, w_z, w_p;
  assign w_s = i_flags[FLAG_S];
  assign w_c = i_flags[FLAG_C];
  assign w_z = i_flags[FLAG_Z];
  assign w_p = i_flags[FLAG_P];
  always_comb begin
    case (i_cond)
      COND_ALWAYS: o_true = 1'b1;
      COND_Z:      o_true = w_z;
      COND_NZ:     o_true = !w_z;
      COND_C:      o_true = w_c;
      COND_NC:     o_true = !w_c;
      COND_S:      o_true = w_s;
      COND_NS:     o_true = !w_s;
      COND_P:      o_true = w_p;
      COND_NP:     o_true = !w_p;
      COND_CZ:     o_true = w_c | w_z;
      COND_NCZ:    o_true = !(w_c | w_z);
      default:     o_true = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: one-entry ALU result buffer to the regfile write port, flags register, branch conditions, bypass.
// ALU_WB_FLAG_SHADOW_EN adds an interrupt shadow copy of the flags (INT_ENTER saves, INT_RETURN restores).
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_sign,
  input  logic              i_carry,
  input  logic              i_zero,
  input  logic              i_parity,
  input  logic [REG_AW-1:0] i_dest,
  input  logic              i_wb_en,
  input  logic              i_flags_en,
  output logic              o_wr_req,
  input  logic              i_wr_ack,
  output logic [REG_AW-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  input  logic              i_flags_ld,
  input  logic [3:0]        i_flags_din,
  output logic [3:0]        o_flags_q,
  input  logic [3:0]        i_cond,
  output logic              o_cond_true,
  input  logic [REG_AW-1:0] i_ra_addr,
  input  logic [REG_AW-1:0] i_rb_addr,
`ifdef ALU_WB_FLAG_SHADOW_EN
  input  logic              i_int_enter,
  input  logic              i_int_return,
`endif
  output logic              o_byp_a_hit,
  output logic              o_byp_b_hit,
  output logic [DATA_W-1:0] o_byp_data
);
  wb_state_t         r_state;
  logic [REG_AW-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [3:0]        r_flags;
  logic              w_full, w_done, w_accept, w_flag_upd;
  logic [3:0]        w_alu_flags, w_flags_nxt;
  assign w_full      = (r_state == WB_FULL);
  assign w_done      = w_full & i_wr_ack;
  assign o_in_ready  = !w_full | i_wr_ack;
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_flag_upd  = w_accept & i_flags_en;
  assign w_alu_flags = {i_sign, i_carry, i_zero, i_parity};
  // A new writeback accept replaces a completing entry in the same cycle, so no bubble.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= WB_EMPTY;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_accept && i_wb_en) begin
      r_state   <= WB_FULL;
      r_wr_addr <= i_dest;
      r_wr_data <= i_result;
    end else if (w_done) begin
      r_state   <= WB_EMPTY;
    end
  end
`ifdef ALU_WB_FLAG_SHADOW_EN
  logic [3:0] r_shadow;
  assign w_flags_nxt = i_int_return ? r_shadow : i_flags_ld ? i_flags_din : w_flag_upd ? w_alu_flags : r_flags;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_shadow <= 4'b0000;
    else if (i_int_enter) r_shadow <= w_flag_upd ? w_alu_flags : r_flags;
  end
`else
  assign w_flags_nxt = i_flags_ld ? i_flags_din : w_flag_upd ? w_alu_flags : r_flags;
`endif
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_flags <= 4'b0000;
    else r_flags <= w_flags_nxt;
  end
  assign o_wr_req    = w_full;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_flags_q   = r_flags;
  assign o_byp_a_hit = w_full & (i_ra_addr == r_wr_addr);
  assign o_byp_b_hit = w_full & (i_rb_addr == r_wr_addr);
  assign o_byp_data  = r_wr_data;
  alu_writeback_cond_eval u_cond (
    .i_flags(r_flags),
    .i_cond (i_cond),
    .o_true (o_cond_true)
  );
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed test-plan steps plus random traffic against a queue-based reference model.
module tb_alu_writeback;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready;
  logic [15:0] result = 0;
  logic        sign = 0, carry = 0, zero = 0, parity = 0;
  logic [3:0]  dest = 0;
  logic        wb_en = 0, flags_en = 0;
  logic        wr_req, wr_ack = 0;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        flags_ld = 0;
  logic [3:0]  flags_din = 0, flags_q;
  logic [3:0]  cond = 0;
  logic        cond_true;
  logic [3:0]  ra_addr = 0, rb_addr = 0;
  logic        int_enter = 0, int_return = 0;
  logic        byp_a_hit, byp_b_hit;
  logic [15:0] byp_data;
  int checks = 0, failures = 0;
  typedef struct {logic [3:0] a; logic [15:0] d;} wr_t;
  wr_t pend[$];
  logic [3:0]  m_addr = 0, m_flags = 0, m_shadow = 0;
  logic [15:0] m_data = 0;
  always #5 clk = ~clk;
  alu_writeback dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_result(result), .i_sign(sign), .i_carry(carry), .i_zero(zero), .i_parity(parity),
    .i_dest(dest), .i_wb_en(wb_en), .i_flags_en(flags_en),
    .o_wr_req(wr_req), .i_wr_ack(wr_ack), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .i_flags_ld(flags_ld), .i_flags_din(flags_din), .o_flags_q(flags_q),
    .i_cond(cond), .o_cond_true(cond_true), .i_ra_addr(ra_addr), .i_rb_addr(rb_addr),
`ifdef ALU_WB_FLAG_SHADOW_EN
    .i_int_enter(int_enter), .i_int_return(int_return),
`endif
    .o_byp_a_hit(byp_a_hit), .o_byp_b_hit(byp_b_hit), .o_byp_data(byp_data)
  );
  function automatic logic cond_ref(logic [3:0] f, logic [3:0] c);
    logic s, cy, z, p;
    logic t [0:10];
    s = f[3]; cy = f[2]; z = f[1]; p = f[0];
    t = '{1'b1, z, !z, cy, !cy, s, !s, p, !p, cy | z, !(cy | z)};
    return (c < 4'd11) ? t[c] : 1'b0;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_model();
    logic busy;
    busy = pend.size() != 0;
    chk("wr_req", {31'd0, wr_req}, {31'd0, busy});
    chk("in_ready", {31'd0, in_ready}, {31'd0, !busy || wr_ack});
    chk("wr_addr", {28'd0, wr_addr}, {28'd0, busy ? pend[0].a : m_addr});
    chk("wr_data", {16'd0, wr_data}, {16'd0, busy ? pend[0].d : m_data});
    chk("flags_q", {28'd0, flags_q}, {28'd0, m_flags});
    chk("cond_true", {31'd0, cond_true}, {31'd0, cond_ref(m_flags, cond)});
    chk("byp_a", {31'd0, byp_a_hit}, {31'd0, busy && ra_addr == pend[0].a});
    chk("byp_b", {31'd0, byp_b_hit}, {31'd0, busy && rb_addr == pend[0].a});
    chk("byp_data", {16'd0, byp_data}, {16'd0, busy ? pend[0].d : m_data});
  endtask
  task automatic model_edge();
    logic ack, rdy, acc;
    logic [3:0] alu_f, old_f, old_sh;
    if (!rst_n) begin
      pend.delete(); m_addr = 0; m_data = 0; m_flags = 0; m_shadow = 0;
      return;
    end
    ack = pend.size() != 0 && wr_ack;
    rdy = pend.size() == 0 || wr_ack;
    acc = in_valid && rdy;
    alu_f = {sign, carry, zero, parity};
    old_f = m_flags; old_sh = m_shadow;
    if (ack) void'(pend.pop_front());
    if (acc && wb_en) begin
      pend.push_back('{dest, result});
      m_addr = dest; m_data = result;
    end
`ifdef ALU_WB_FLAG_SHADOW_EN
    if (int_enter) m_shadow = (acc && flags_en) ? alu_f : old_f;
    if (int_return) m_flags = old_sh;
    else
`endif
    if (flags_ld) m_flags = flags_din;
    else if (acc && flags_en) m_flags = alu_f;
  endtask
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic put(logic v, logic [15:0] r, logic [3:0] d, logic wb, logic fe, logic [3:0] f, logic ack);
    in_valid = v; result = r; dest = d; wb_en = wb; flags_en = fe;
    {sign, carry, zero, parity} = f; wr_ack = ack;
  endtask
  initial begin
    tick(); tick();
    rst_n = 1;
    tick();
    // ADD with a stalled write port
    put(1, 16'h1234, 3, 1, 1, 4'b0000, 0);
    tick();
    put(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("add_req", {31'd0, wr_req}, 32'd1);
      chk("add_addr", {28'd0, wr_addr}, 32'd3);
      chk("add_data", {16'd0, wr_data}, 32'h1234);
      chk("add_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    wr_ack = 1; tick();
    wr_ack = 0; #1;
    chk("add_release", {31'd0, wr_req}, 32'd0);
    tick();
    // back-to-back with no bubble
    put(1, 16'h00FF, 5, 1, 0, 0, 0); tick();
    put(1, 16'hFF00, 6, 1, 0, 0, 1); #1;
    chk("b2b_first", {28'd0, wr_addr, 16'd0}, {28'd5, 16'd0});
    tick();
    put(0, 0, 0, 0, 0, 0, 1); #1;
    chk("b2b_req2", {31'd0, wr_req}, 32'd1);
    chk("b2b_data2", {16'd0, wr_data}, 32'hFF00);
    tick();
    put(0, 0, 0, 0, 0, 0, 0); tick();
    // CMP sets flags only
    put(1, 16'h5555, 9, 0, 1, 4'b0010, 0); tick();
    put(0, 0, 0, 0, 0, 0, 0); cond = 1; #1;
    chk("cmp_noreq", {31'd0, wr_req}, 32'd0);
    chk("cmp_z", {31'd0, flags_q[1]}, 32'd1);
    chk("cmp_cond1", {31'd0, cond_true}, 32'd1);
    cond = 2; #1;
    chk("cmp_cond2", {31'd0, cond_true}, 32'd0);
    tick();
    // bypass
    put(1, 16'hBEEF, 7, 1, 0, 0, 0); tick();
    put(0, 0, 0, 0, 0, 0, 0); ra_addr = 7; rb_addr = 2; #1;
    chk("byp_a_hit", {31'd0, byp_a_hit}, 32'd1);
    chk("byp_b_hit", {31'd0, byp_b_hit}, 32'd0);
    chk("byp_beef", {16'd0, byp_data}, 32'hBEEF);
    wr_ack = 1; #1;
    chk("byp_ack_hit", {31'd0, byp_a_hit}, 32'd1);
    tick();
    wr_ack = 0;
    // FLAGS_LD beats a flags accept
    put(1, 0, 0, 0, 1, 4'b0101, 0); flags_ld = 1; flags_din = 4'b1010; tick();
    put(0, 0, 0, 0, 0, 0, 0); flags_ld = 0; #1;
    chk("ld_wins", {28'd0, flags_q}, 32'hA);
`ifdef ALU_WB_FLAG_SHADOW_EN
    int_enter = 1; tick(); int_enter = 0;
    flags_ld = 1; flags_din = 4'b0000; tick(); flags_ld = 0;
    int_return = 1; tick(); int_return = 0; #1;
    chk("shadow_restore", {28'd0, flags_q}, 32'hA);
`endif
    // reset mid-write
    put(1, 16'hCAFE, 4, 1, 1, 4'b1111, 0); tick();
    put(0, 0, 0, 0, 0, 0, 0); rst_n = 0; tick(); rst_n = 1; #1;
    chk("rst_req", {31'd0, wr_req}, 32'd0);
    chk("rst_flags", {28'd0, flags_q}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = $urandom_range(0, 59) != 0;
      put($urandom_range(0, 2) != 0, 16'($urandom), 4'($urandom), $urandom_range(0, 3) != 0,
          1'($urandom), 4'($urandom), 1'($urandom));
      flags_ld = $urandom_range(0, 9) == 0;
      flags_din = 4'($urandom);
      cond = 4'($urandom);
      ra_addr = 4'($urandom);
      rb_addr = 4'($urandom);
      int_enter = $urandom_range(0, 7) == 0;
      int_return = $urandom_range(0, 7) == 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
